// File: rtl/y86_pkg.sv
// ---------------------------------------------------------------------------
// y86_pkg
// Shared constants for the Y86-64 pipeline:
//   - instruction codes (IHALT..IPOPQ)
//   - ALU operation encodings
//   - status codes (AOK/HLT/ADR/INS)
//   - RNONE register ID
//   - jXX/cmovXX condition function codes
// ---------------------------------------------------------------------------
package y86_pkg;

    localparam int DEF_W = 64;

    // Instruction codes
    localparam logic [3:0] IHALT   = 4'h0;
    localparam logic [3:0] INOP    = 4'h1;
    localparam logic [3:0] IRRMOVQ = 4'h2;
    localparam logic [3:0] IIRMOVQ = 4'h3;
    localparam logic [3:0] IRMMOVQ = 4'h4;
    localparam logic [3:0] IMRMOVQ = 4'h5;
    localparam logic [3:0] IOPQ    = 4'h6;
    localparam logic [3:0] IJXX    = 4'h7;
    localparam logic [3:0] ICALL   = 4'h8;
    localparam logic [3:0] IRET    = 4'h9;
    localparam logic [3:0] IPUSHQ  = 4'hA;
    localparam logic [3:0] IPOPQ   = 4'hB;

    // ALU operations
    localparam logic [1:0] ALUADD = 2'b00;
    localparam logic [1:0] ALUSUB = 2'b01;
    localparam logic [1:0] ALUAND = 2'b10;
    localparam logic [1:0] ALUXOR = 2'b11;

    // Status codes
    localparam logic [3:0] SAOK = 4'h1;
    localparam logic [3:0] SHLT = 4'h2;
    localparam logic [3:0] SADR = 4'h3;
    localparam logic [3:0] SINS = 4'h4;

    // "No register" ID
    localparam logic [3:0] RNONE = 4'hF;

    // Condition function codes
    localparam logic [3:0] C_YES = 4'h0;
    localparam logic [3:0] C_LE  = 4'h1;
    localparam logic [3:0] C_L   = 4'h2;
    localparam logic [3:0] C_E   = 4'h3;
    localparam logic [3:0] C_NE  = 4'h4;
    localparam logic [3:0] C_GE  = 4'h5;
    localparam logic [3:0] C_G   = 4'h6;

    // True when a status code means the pipeline is stopping on an exception.
    function automatic logic is_exception(input logic [3:0] stat);
        return (stat == SHLT) || (stat == SADR) || (stat == SINS);
    endfunction

endpackage

// File: rtl/y86_alu.sv
// ---------------------------------------------------------------------------
// y86_alu
// Combinational W-bit ALU.
//   alufun_i : operation (add/sub/and/xor)
//   inp1_i   : first operand (sub computes inp1 - inp2)
//   inp2_i   : second operand
//   out_o    : result
//   ovf_o    : signed overflow for add/sub, 0 for logical ops
// ---------------------------------------------------------------------------
module y86_alu
    import y86_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic [1:0]   alufun_i,
    input  logic [W-1:0] inp1_i,
    input  logic [W-1:0] inp2_i,
    output logic [W-1:0] out_o,
    output logic         ovf_o
);

    always_comb begin
        out_o = '0;
        ovf_o = 1'b0;
        case (alufun_i)
            ALUADD: begin
                out_o = inp1_i + inp2_i;
                // Same-sign operands producing a different-sign result.
                ovf_o = (inp1_i[W-1] == inp2_i[W-1]) && (out_o[W-1] != inp1_i[W-1]);
            end
            ALUSUB: begin
                out_o = inp1_i - inp2_i;
                // Opposite-sign operands where the result sign leaves inp1's sign.
                ovf_o = (inp1_i[W-1] != inp2_i[W-1]) && (out_o[W-1] != inp1_i[W-1]);
            end
            ALUAND: out_o = inp1_i & inp2_i;
            default: out_o = inp1_i ^ inp2_i;
        endcase
    end

endmodule

// File: rtl/y86_cond_eval.sv
// ---------------------------------------------------------------------------
// y86_cond_eval
// Evaluates a jXX/cmovXX condition from the condition codes.
//   cc_i   : {ZF, SF, OF}
//   ifun_i : condition function code
//   cnd_o  : condition result (0 for undefined function codes)
// ---------------------------------------------------------------------------
module y86_cond_eval
    import y86_pkg::*;
(
    input  logic [2:0] cc_i,
    input  logic [3:0] ifun_i,
    output logic       cnd_o
);

    logic zf, sf, of;

    assign zf = cc_i[2];
    assign sf = cc_i[1];
    assign of = cc_i[0];

    always_comb begin
        cnd_o = 1'b0;
        case (ifun_i)
            C_YES: cnd_o = 1'b1;
            C_LE:  cnd_o = (sf ^ of) | zf;
            C_L:   cnd_o = sf ^ of;
            C_E:   cnd_o = zf;
            C_NE:  cnd_o = ~zf;
            C_GE:  cnd_o = ~(sf ^ of);
            C_G:   cnd_o = ~(sf ^ of) & ~zf;
            default: cnd_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/y86_execute_stage.sv
// ---------------------------------------------------------------------------
// y86_execute_stage
// Execute stage of the pipelined Y86-64 core: ALU operand/function selection,
// condition-code register, condition evaluation and the E/M pipeline register.
//   clk, rst              : clock, asynchronous active-high reset
//   E_*                   : D/E pipeline register fields
//   m_stat, W_stat        : downstream status, used to suppress CC updates
//   M_bubble              : load a bubble into E/M
//   e_valE, e_dstE, e_Cnd : combinational results for forwarding/branching
//   cc                    : registered {ZF,SF,OF}
//   M_*                   : registered E/M fields
// ---------------------------------------------------------------------------
module y86_execute_stage
    import y86_pkg::*;
#(
    parameter int         W         = 64,
    parameter logic [3:0] RNONE_ID  = RNONE
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [3:0]   E_stat,
    input  logic [3:0]   E_icode,
    input  logic [3:0]   E_ifun,
    input  logic [W-1:0] E_valC,
    input  logic [W-1:0] E_valA,
    input  logic [W-1:0] E_valB,
    input  logic [3:0]   E_dstE,
    input  logic [3:0]   E_dstM,
    input  logic [3:0]   m_stat,
    input  logic [3:0]   W_stat,
    input  logic         M_bubble,
    output logic [W-1:0] e_valE,
    output logic [3:0]   e_dstE,
    output logic         e_Cnd,
    output logic [2:0]   cc,
    output logic [3:0]   M_stat,
    output logic [3:0]   M_icode,
    output logic         M_Cnd,
    output logic [W-1:0] M_valE,
    output logic [W-1:0] M_valA,
    output logic [3:0]   M_dstE,
    output logic [3:0]   M_dstM
);

    localparam logic [W-1:0] EIGHT = W'(8);

    logic [W-1:0] alu_a, alu_b;
    logic [1:0]   alufun;
    logic         alu_ovf;
    logic         set_cc;
    logic [2:0]   cc_q, cc_d;

    // Operand A: register, constant or stack-pointer adjustment.
    always_comb begin
        alu_a = '0;
        case (E_icode)
            IRRMOVQ, IOPQ:            alu_a = E_valA;
            IIRMOVQ, IRMMOVQ, IMRMOVQ: alu_a = E_valC;
            ICALL, IPUSHQ:            alu_a = -EIGHT;
            IRET, IPOPQ:              alu_a = EIGHT;
            default:                  alu_a = '0;
        endcase
    end

    // Operand B: base register for memory/stack ops and OPq.
    always_comb begin
        alu_b = '0;
        case (E_icode)
            IRMMOVQ, IMRMOVQ, IOPQ, ICALL, IRET, IPUSHQ, IPOPQ: alu_b = E_valB;
            default: alu_b = '0;
        endcase
    end

    assign alufun = (E_icode == IOPQ) ? E_ifun[1:0] : ALUADD;

    // inp1 = B, inp2 = A so subq produces valB - valA.
    y86_alu #(.W(W)) u_alu (
        .alufun_i (alufun),
        .inp1_i   (alu_b),
        .inp2_i   (alu_a),
        .out_o    (e_valE),
        .ovf_o    (alu_ovf)
    );

    // Condition codes are frozen once an older instruction has faulted.
    assign set_cc = (E_icode == IOPQ) && !is_exception(m_stat) && !is_exception(W_stat);

    always_comb begin
        cc_d = cc_q;
        if (set_cc) begin
            cc_d[2] = (e_valE == '0);
            cc_d[1] = e_valE[W-1];
            cc_d[0] = alu_ovf;  // ALU already reports 0 for and/xor
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cc_q <= 3'b100;
        else     cc_q <= cc_d;
    end

    assign cc = cc_q;

    // Condition is evaluated from the codes before this cycle's update.
    y86_cond_eval u_cond (
        .cc_i   (cc_q),
        .ifun_i (E_ifun),
        .cnd_o  (e_Cnd)
    );

    // A failed cmov becomes a write to no register.
    assign e_dstE = ((E_icode == IRRMOVQ) && !e_Cnd) ? RNONE_ID : E_dstE;

    // E/M pipeline register
    always_ff @(posedge clk or posedge rst) begin
        if (rst || M_bubble) begin
            M_stat  <= SAOK;
            M_icode <= INOP;
            M_Cnd   <= 1'b0;
            M_valE  <= '0;
            M_valA  <= '0;
            M_dstE  <= RNONE_ID;
            M_dstM  <= RNONE_ID;
        end else begin
            M_stat  <= E_stat;
            M_icode <= E_icode;
            M_Cnd   <= e_Cnd;
            M_valE  <= e_valE;
            M_valA  <= E_valA;
            M_dstE  <= e_dstE;
            M_dstM  <= E_dstM;
        end
    end

endmodule

// File: tb/tb_y86_execute_stage.sv
module tb_y86_execute_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  E_stat, E_icode, E_ifun, E_dstE, E_dstM, m_stat, W_stat;
    logic [63:0] E_valC, E_valA, E_valB;
    logic        M_bubble;
    logic [63:0] e_valE, M_valE, M_valA;
    logic [3:0]  e_dstE, M_stat, M_icode, M_dstE, M_dstM;
    logic        e_Cnd, M_Cnd;
    logic [2:0]  cc;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    y86_execute_stage #(.W(64)) dut (
        .clk(clk), .rst(rst),
        .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun),
        .E_valC(E_valC), .E_valA(E_valA), .E_valB(E_valB),
        .E_dstE(E_dstE), .E_dstM(E_dstM),
        .m_stat(m_stat), .W_stat(W_stat), .M_bubble(M_bubble),
        .e_valE(e_valE), .e_dstE(e_dstE), .e_Cnd(e_Cnd), .cc(cc),
        .M_stat(M_stat), .M_icode(M_icode), .M_Cnd(M_Cnd),
        .M_valE(M_valE), .M_valA(M_valA), .M_dstE(M_dstE), .M_dstM(M_dstM)
    );

    // Apply one E-stage instruction on the falling edge and let it settle.
    task automatic drive(input logic [3:0] icode, input logic [3:0] ifun,
                         input logic [63:0] va, input logic [63:0] vb,
                         input logic [63:0] vc, input logic [3:0] de,
                         input logic [3:0] dm);
        @(negedge clk);
        E_stat = 4'h1; E_icode = icode; E_ifun = ifun;
        E_valA = va; E_valB = vb; E_valC = vc; E_dstE = de; E_dstM = dm;
        #1;
        $display("txn t=%0t icode=%h ifun=%h valA=%h valB=%h valC=%h -> e_valE=%h e_Cnd=%b e_dstE=%h cc=%b",
                 $time, icode, ifun, va, vb, vc, e_valE, e_Cnd, e_dstE, cc);
    endtask

    task automatic clock_edge;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        #2;
        total++; if (cc !== 3'b100)   begin bad++; $display("FAIL reset_cc got=%b exp=100", cc); end
        total++; if (M_icode !== 4'h1) begin bad++; $display("FAIL reset_icode got=%h exp=1", M_icode); end
        total++; if (M_dstE !== 4'hF)  begin bad++; $display("FAIL reset_dstE got=%h exp=F", M_dstE); end
        total++; if (M_stat !== 4'h1)  begin bad++; $display("FAIL reset_stat got=%h exp=1", M_stat); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_addq;
        drive(4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 64'h0, 4'h2, 4'hF);
        total++; if (e_valE !== 64'h8000_0000_0000_0000) begin bad++; $display("FAIL add_valE got=%h exp=8000000000000000", e_valE); end
        clock_edge();
        total++; if (cc !== 3'b011) begin bad++; $display("FAIL add_cc got=%b exp=011", cc); end
        total++; if (M_valE !== 64'h8000_0000_0000_0000) begin bad++; $display("FAIL add_MvalE got=%h exp=8000000000000000", M_valE); end
        total++; if (M_icode !== 4'h6 || M_dstE !== 4'h2) begin bad++; $display("FAIL add_Mfields got=%h/%h exp=6/2", M_icode, M_dstE); end
    endtask

    task automatic test_subq_cond;
        drive(4'h6, 4'h1, 64'h5, 64'h5, 64'h0, 4'h2, 4'hF);
        total++; if (e_valE !== 64'h0) begin bad++; $display("FAIL sub_valE got=%h exp=0", e_valE); end
        clock_edge();
        total++; if (cc !== 3'b100) begin bad++; $display("FAIL sub_cc got=%b exp=100", cc); end
        drive(4'h7, 4'h2, 64'h0, 64'h0, 64'h40, 4'hF, 4'hF);
        total++; if (e_Cnd !== 1'b0) begin bad++; $display("FAIL jl_zero got=%b exp=0", e_Cnd); end
        drive(4'h7, 4'h1, 64'h0, 64'h0, 64'h40, 4'hF, 4'hF);
        total++; if (e_Cnd !== 1'b1) begin bad++; $display("FAIL jle_zero got=%b exp=1", e_Cnd); end
        drive(4'h7, 4'h5, 64'h0, 64'h0, 64'h40, 4'hF, 4'hF);
        total++; if (e_Cnd !== 1'b1) begin bad++; $display("FAIL jge_zero got=%b exp=1", e_Cnd); end
        drive(4'h7, 4'h6, 64'h0, 64'h0, 64'h40, 4'hF, 4'hF);
        total++; if (e_Cnd !== 1'b0) begin bad++; $display("FAIL jg_zero got=%b exp=0", e_Cnd); end
        drive(4'h7, 4'h7, 64'h0, 64'h0, 64'h40, 4'hF, 4'hF);
        total++; if (e_Cnd !== 1'b0) begin bad++; $display("FAIL jbad_ifun got=%b exp=0", e_Cnd); end
    endtask

    task automatic test_cmov;
        drive(4'h2, 4'h4, 64'h55, 64'h999, 64'h0, 4'h3, 4'hF);
        total++; if (e_Cnd !== 1'b0 || e_dstE !== 4'hF) begin bad++; $display("FAIL cmovne_dst got=%b/%h exp=0/F", e_Cnd, e_dstE); end
        total++; if (e_valE !== 64'h55) begin bad++; $display("FAIL cmovne_valE got=%h exp=55", e_valE); end
        clock_edge();
        total++; if (M_valE !== 64'h55 || M_Cnd !== 1'b0 || M_dstE !== 4'hF) begin bad++; $display("FAIL cmovne_M got=%h/%b/%h exp=55/0/F", M_valE, M_Cnd, M_dstE); end
        drive(4'h2, 4'h3, 64'h55, 64'h999, 64'h0, 4'h3, 4'hF);
        total++; if (e_Cnd !== 1'b1 || e_dstE !== 4'h3) begin bad++; $display("FAIL cmove_dst got=%b/%h exp=1/3", e_Cnd, e_dstE); end
    endtask

    task automatic test_stack_addr;
        drive(4'hA, 4'h0, 64'h77, 64'h100, 64'h0, 4'h4, 4'hF);
        total++; if (e_valE !== 64'hF8) begin bad++; $display("FAIL push_valE got=%h exp=f8", e_valE); end
        clock_edge();
        total++; if (cc !== 3'b100 || M_valA !== 64'h77) begin bad++; $display("FAIL push_cc_valA got=%b/%h exp=100/77", cc, M_valA); end
        drive(4'hB, 4'h0, 64'h100, 64'h100, 64'h0, 4'h4, 4'h5);
        total++; if (e_valE !== 64'h108) begin bad++; $display("FAIL pop_valE got=%h exp=108", e_valE); end
        clock_edge();
        total++; if (cc !== 3'b100 || M_dstM !== 4'h5) begin bad++; $display("FAIL pop_cc_dstM got=%b/%h exp=100/5", cc, M_dstM); end
        drive(4'h3, 4'h0, 64'h0, 64'h999, 64'h1234, 4'h6, 4'hF);
        total++; if (e_valE !== 64'h1234) begin bad++; $display("FAIL irmov_valE got=%h exp=1234", e_valE); end
        drive(4'h5, 4'h0, 64'h0, 64'h100, 64'h8, 4'hF, 4'h6);
        total++; if (e_valE !== 64'h108) begin bad++; $display("FAIL mrmov_valE got=%h exp=108", e_valE); end
        drive(4'h8, 4'h0, 64'h0, 64'h200, 64'h0, 4'h4, 4'hF);
        total++; if (e_valE !== 64'h1F8) begin bad++; $display("FAIL call_valE got=%h exp=1f8", e_valE); end
    endtask

    task automatic test_exception;
        m_stat = 4'h3; M_bubble = 1'b1;
        drive(4'h6, 4'h3, 64'h1, 64'h2, 64'h0, 4'h2, 4'h7);
        total++; if (e_valE !== 64'h3) begin bad++; $display("FAIL xor_valE got=%h exp=3", e_valE); end
        clock_edge();
        total++; if (cc !== 3'b100) begin bad++; $display("FAIL xor_mstat_cc got=%b exp=100", cc); end
        total++; if (M_icode !== 4'h1 || M_dstE !== 4'hF || M_dstM !== 4'hF || M_valE !== 64'h0) begin bad++; $display("FAIL bubble_M got=%h/%h/%h/%h exp=1/F/F/0", M_icode, M_dstE, M_dstM, M_valE); end
        @(negedge clk);
        m_stat = 4'h1; M_bubble = 1'b0; W_stat = 4'h2;
        clock_edge();
        total++; if (cc !== 3'b100) begin bad++; $display("FAIL xor_Wstat_cc got=%b exp=100", cc); end
        total++; if (M_icode !== 4'h6 || M_valE !== 64'h3) begin bad++; $display("FAIL xor_Wstat_load got=%h/%h exp=6/3", M_icode, M_valE); end
        @(negedge clk);
        W_stat = 4'h1;
        clock_edge();
        total++; if (cc !== 3'b000) begin bad++; $display("FAIL xor_cc got=%b exp=000", cc); end
    endtask

    task automatic test_sub_ovf_and;
        drive(4'h6, 4'h1, 64'h1, 64'h8000_0000_0000_0000, 64'h0, 4'h2, 4'hF);
        total++; if (e_valE !== 64'h7FFF_FFFF_FFFF_FFFF) begin bad++; $display("FAIL subovf_valE got=%h exp=7fffffffffffffff", e_valE); end
        clock_edge();
        total++; if (cc !== 3'b001) begin bad++; $display("FAIL subovf_cc got=%b exp=001", cc); end
        drive(4'h7, 4'h2, 64'h0, 64'h0, 64'h0, 4'hF, 4'hF);
        total++; if (e_Cnd !== 1'b1) begin bad++; $display("FAIL jl_ovf got=%b exp=1", e_Cnd); end
        drive(4'h6, 4'h2, 64'hF0, 64'h0F, 64'h0, 4'h2, 4'hF);
        total++; if (e_valE !== 64'h0) begin bad++; $display("FAIL and_valE got=%h exp=0", e_valE); end
        clock_edge();
        total++; if (cc !== 3'b100) begin bad++; $display("FAIL and_cc got=%b exp=100", cc); end
    endtask

    task automatic test_rst_mid;
        drive(4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 64'h0, 4'h2, 4'h9);
        clock_edge();
        total++; if (cc !== 3'b011 || M_icode !== 4'h6) begin bad++; $display("FAIL pre_rst got=%b/%h exp=011/6", cc, M_icode); end
        #2 rst = 1'b1;
        #1;
        $display("txn t=%0t async reset asserted", $time);
        total++; if (cc !== 3'b100) begin bad++; $display("FAIL rstmid_cc got=%b exp=100", cc); end
        total++; if (M_icode !== 4'h1 || M_dstE !== 4'hF || M_stat !== 4'h1 || M_dstM !== 4'hF) begin bad++; $display("FAIL rstmid_M got=%h/%h/%h/%h exp=1/F/1/F", M_icode, M_dstE, M_stat, M_dstM); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        E_stat = 4'h1; E_icode = 4'h1; E_ifun = 4'h0;
        E_valA = '0; E_valB = '0; E_valC = '0; E_dstE = 4'hF; E_dstM = 4'hF;
        m_stat = 4'h1; W_stat = 4'h1; M_bubble = 1'b0;

        test_reset();
        test_addq();
        test_subq_cond();
        test_cmov();
        test_stack_addr();
        test_exception();
        test_sub_ovf_and();
        test_rst_mid();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard stop in case anything above stalls.
    initial begin
        #100000;
        $display("FAIL timeout reached t=%0t", $time);
        $fatal(1, "timeout");
    end

endmodule
